cam_cfg_ctrl: RTL and testbench

- Brings up the MIPI camera sensor after power-on. Sequences the sensor reset pin (`mipi_rst`), then walks a register table and writes each entry over the SCCB/I2C control bus (`mipi_scl`/`mipi_sda`).
- Sits in `top` beside the MIPI receive subsystem and runs on `clk_50m`.
- The register table is an external synchronous ROM.
- Open-drain pads (IOBUF) are instantiated in `top`; this block only drives output enables and reads the line values.

---
 rtl/cam_cfg_pkg.sv | 21 ++
 rtl/i2c_byte_wr.sv | 109 ++++++++++
 rtl/cam_cfg_ctrl.sv | 140 ++++++++++++++
 tb/tb_cam_cfg_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared types and table-entry helpers for the camera bring-up controller.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_HOLD, S_RST_WAIT, S_FETCH, S_WRITE, S_DELAY, S_DONE, S_ERROR
  } cfg_state_e;

  typedef enum logic [1:0] {PH_START, PH_BIT, PH_ACK, PH_STOP} i2c_phase_e;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFFE;

  function automatic logic [15:0] ent_addr(input logic [23:0] e);
    return e[23:8];
  endfunction

  function automatic logic [7:0] ent_data(input logic [23:0] e);
    return e[7:0];
  endfunction

endpackage

// File: rtl/i2c_byte_wr.sv
// One-byte SCCB/I2C writer: emits START on the first byte of a transfer,
// keeps SCL low between bytes, and closes with STOP on `last` or NACK.
module i2c_byte_wr import cam_cfg_pkg::*; #(
  parameter int QTR = 125
) (
  input  logic       clk_50m_i,
  input  logic       rst_ni,
  input  logic       go_i,
  input  logic       last_i,
  input  logic [7:0] byte_i,
  input  logic       sda_in_i,
  output logic       rdy_o,
  output logic       ack_ok_o,
  output logic       nack_o,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);

  localparam logic [15:0] QM1 = 16'(QTR - 1);

  i2c_phase_e  ph_q;
  logic [15:0] qcnt_q;
  logic [1:0]  qtr_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        act_q, open_q, last_q, nk_q, ack_q, nak_q, scl_q, sda_q;
  logic        tick;

  assign tick     = act_q && (qcnt_q == QM1);
  assign rdy_o    = ~act_q;
  assign ack_ok_o = ack_q;
  assign nack_o   = nak_q;
  assign scl_oe_o = scl_q;
  assign sda_oe_o = sda_q;

  always_ff @(posedge clk_50m_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_q <= PH_START; qcnt_q <= '0; qtr_q <= '0; bit_q <= '0; sh_q <= '0;
      act_q <= 1'b0; open_q <= 1'b0; last_q <= 1'b0; nk_q <= 1'b0;
      ack_q <= 1'b0; nak_q <= 1'b0; scl_q <= 1'b0; sda_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      nak_q <= 1'b0;
      if (!act_q) begin
        qcnt_q <= '0;
        if (go_i) begin
          act_q <= 1'b1; sh_q <= byte_i; last_q <= last_i; qtr_q <= '0; bit_q <= 3'd7;
          if (open_q) begin
            ph_q <= PH_BIT; scl_q <= 1'b1; sda_q <= ~byte_i[7];
          end else begin
            ph_q <= PH_START; scl_q <= 1'b0; sda_q <= 1'b0;
          end
        end
      end else if (!tick) begin
        qcnt_q <= qcnt_q + 16'd1;
      end else begin
        qcnt_q <= '0;
        qtr_q  <= qtr_q + 2'd1;
        case (ph_q)
          PH_START:
            if (qtr_q == 2'd0) sda_q <= 1'b1;
            else begin
              ph_q <= PH_BIT; qtr_q <= '0; open_q <= 1'b1;
              scl_q <= 1'b1; sda_q <= ~sh_q[7];
            end
          PH_BIT:
            case (qtr_q)
              2'd1: scl_q <= 1'b0;
              2'd3: begin
                scl_q <= 1'b1;
                if (bit_q == 3'd0) begin
                  ph_q <= PH_ACK; sda_q <= 1'b0;
                end else begin
                  bit_q <= bit_q - 3'd1; sh_q <= {sh_q[6:0], 1'b0}; sda_q <= ~sh_q[6];
                end
              end
              default: ;
            endcase
          PH_ACK:
            case (qtr_q)
              2'd1: scl_q <= 1'b0;
              2'd2: nk_q <= sda_in_i;
              2'd3: begin
                scl_q <= 1'b1;
                // Between bytes SCL stays low with SDA released until the next go.
                if (nk_q || last_q) begin
                  ph_q <= PH_STOP; sda_q <= 1'b1;
                end else begin
                  act_q <= 1'b0; ack_q <= 1'b1;
                end
              end
              default: ;
            endcase
          PH_STOP:
            case (qtr_q)
              2'd0: scl_q <= 1'b0;
              2'd1: sda_q <= 1'b0;
              default: begin
                act_q <= 1'b0; open_q <= 1'b0; qtr_q <= '0;
                ack_q <= ~nk_q; nak_q <= nk_q;
              end
            endcase
          default: ph_q <= PH_START;
        endcase
      end
    end
  end

endmodule

// File: rtl/cam_cfg_ctrl.sv
// MIPI sensor bring-up: sensor reset sequencing, then a walk of the register
// ROM issuing one I2C byte-write per entry, with delay and end-marker entries.
module cam_cfg_ctrl import cam_cfg_pkg::*; #(
  parameter int         CLK_HZ       = 50_000_000,
  parameter int         I2C_HZ       = 100_000,
  parameter logic [6:0] DEV_ADDR     = 7'h36,
  parameter int         RST_HOLD_CYC = 500_000,
  parameter int         POST_RST_CYC = 1_000_000,
  parameter int         MS_CYC       = CLK_HZ / 1000,
  parameter int         IDX_W        = 8
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [23:0]      tbl_entry,
  output logic             mipi_rst,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);

  localparam int          QTR  = CLK_HZ / (4 * I2C_HZ);
  localparam logic [31:0] MS_W = 32'(MS_CYC);

  cfg_state_e       st_q;
  logic [31:0]      cnt_q;
  logic [IDX_W-1:0] tbl_idx_q, err_idx_q;
  logic [23:0]      entry_q;
  logic [1:0]       bsel_q;
  logic             go_q, fwait_q, mipi_rst_q, busy_q, done_q, error_q;
  logic             rdy, ack_ok, nack, adv;
  logic [15:0]      ra;
  logic [7:0]       wbyte;

  assign ra = ent_addr(entry_q);

  always_comb begin
    wbyte = {DEV_ADDR, 1'b0};
    case (bsel_q)
      2'd1:    wbyte = ra[15:8];
      2'd2:    wbyte = ra[7:0];
      2'd3:    wbyte = ent_data(entry_q);
      default: wbyte = {DEV_ADDR, 1'b0};
    endcase
  end

  // Entry finished: a write fully ACKed, a delay expired, or a zero-length delay.
  always_comb begin
    adv = 1'b0;
    case (st_q)
      S_WRITE: adv = ack_ok && (bsel_q == 2'd3);
      S_DELAY: adv = (cnt_q == 32'd0);
      S_FETCH: adv = !fwait_q && ent_addr(tbl_entry) == CFG_DELAY && ent_data(tbl_entry) == 8'd0;
      default: adv = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= S_IDLE; cnt_q <= '0; tbl_idx_q <= '0; err_idx_q <= '0; entry_q <= '0;
      bsel_q <= '0; go_q <= 1'b0; fwait_q <= 1'b0;
      mipi_rst_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
    end else begin
      go_q <= 1'b0;
      case (st_q)
        S_IDLE, S_DONE, S_ERROR:
          if (start) begin
            done_q <= 1'b0; error_q <= 1'b0; mipi_rst_q <= 1'b0; busy_q <= 1'b1;
            cnt_q <= 32'(RST_HOLD_CYC - 1); st_q <= S_RST_HOLD;
          end
        S_RST_HOLD:
          if (cnt_q == 32'd0) begin
            mipi_rst_q <= 1'b1; cnt_q <= 32'(POST_RST_CYC - 1); st_q <= S_RST_WAIT;
          end else cnt_q <= cnt_q - 32'd1;
        S_RST_WAIT:
          if (cnt_q == 32'd0) begin
            tbl_idx_q <= '0; fwait_q <= 1'b1; st_q <= S_FETCH;
          end else cnt_q <= cnt_q - 32'd1;
        S_FETCH:
          if (fwait_q) fwait_q <= 1'b0;
          else begin
            entry_q <= tbl_entry;
            if (ent_addr(tbl_entry) == CFG_END) begin
              st_q <= S_DONE; busy_q <= 1'b0; done_q <= 1'b1;
            end else if (ent_addr(tbl_entry) == CFG_DELAY) begin
              if (ent_data(tbl_entry) != 8'd0) begin
                cnt_q <= {24'd0, ent_data(tbl_entry)} * MS_W - 32'd1;
                st_q  <= S_DELAY;
              end
            end else begin
              bsel_q <= '0; go_q <= 1'b1; st_q <= S_WRITE;
            end
          end
        S_WRITE:
          if (nack) begin
            err_idx_q <= tbl_idx_q; error_q <= 1'b1; busy_q <= 1'b0; st_q <= S_ERROR;
          end else if (ack_ok && bsel_q != 2'd3) begin
            bsel_q <= bsel_q + 2'd1; go_q <= 1'b1;
          end
        S_DELAY:
          if (cnt_q != 32'd0) cnt_q <= cnt_q - 32'd1;
        default: st_q <= S_IDLE;
      endcase
      if (adv) begin
        if (&tbl_idx_q) begin
          st_q <= S_DONE; busy_q <= 1'b0; done_q <= 1'b1;
        end else begin
          tbl_idx_q <= tbl_idx_q + 1'b1; fwait_q <= 1'b1; st_q <= S_FETCH;
        end
      end
    end
  end

  i2c_byte_wr #(.QTR(QTR)) u_i2c (
    .clk_50m_i (clk_50m),
    .rst_ni    (rst_n),
    .go_i      (go_q),
    .last_i    (bsel_q == 2'd3),
    .byte_i    (wbyte),
    .sda_in_i  (sda_in),
    .rdy_o     (rdy),
    .ack_ok_o  (ack_ok),
    .nack_o    (nack),
    .scl_oe_o  (scl_oe),
    .sda_oe_o  (sda_oe)
  );

  assign tbl_idx  = tbl_idx_q;
  assign err_idx  = err_idx_q;
  assign mipi_rst = mipi_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_cam_cfg_ctrl.sv
// Bench for cam_cfg_ctrl: ROM model, I2C slave/bus monitor and a table-walk
// reference that predicts the bytes, STOPs and status of each run.
module tb_cam_cfg_ctrl;

  localparam int QTR  = 2;
  localparam int HOLD = 40;
  localparam int POST = 60;
  localparam int MSC  = 20;
  localparam int NENT = 8;
  localparam logic [6:0] DEV = 7'h36;

  logic       clk = 1'b0, rst_n, start, sda_in, mipi_rst, scl_oe, sda_oe, busy, done, error;
  logic [2:0] tbl_idx, err_idx;
  logic [23:0] tbl_entry;

  always #5 clk = ~clk;

  cam_cfg_ctrl #(
    .CLK_HZ(800), .I2C_HZ(100), .DEV_ADDR(DEV), .RST_HOLD_CYC(HOLD),
    .POST_RST_CYC(POST), .MS_CYC(MSC), .IDX_W(3)
  ) dut (
    .clk_50m(clk), .rst_n(rst_n), .start(start), .tbl_idx(tbl_idx),
    .tbl_entry(tbl_entry), .mipi_rst(mipi_rst), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_in(sda_in), .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  logic [23:0] rom [NENT];
  always @(posedge clk) tbl_entry <= rom[tbl_idx];

  // Slave / bus monitor
  int          cyc = 0, bitn = 0, nack_at = 0;
  logic        scl_p = 1'b1, sda_p = 1'b1, slv_pull = 1'b0, mon_clr = 1'b0;
  logic        scl_l, sda_l;
  logic [7:0]  sh;
  logic [7:0]  got_q[$];
  int          start_t[$], stop_t[$];

  assign scl_l  = ~scl_oe;
  assign sda_l  = ~(sda_oe | slv_pull);
  assign sda_in = sda_l;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    scl_p <= scl_l;
    sda_p <= sda_l;
    if (mon_clr) begin
      got_q.delete(); start_t.delete(); stop_t.delete(); bitn = 0; slv_pull <= 1'b0;
    end else if (scl_l && scl_p && sda_p && !sda_l) begin
      start_t.push_back(cyc); bitn = 0;
    end else if (scl_l && scl_p && !sda_p && sda_l) begin
      stop_t.push_back(cyc);
    end else if (scl_l && !scl_p) begin
      if (bitn < 8) begin
        sh = {sh[6:0], sda_l}; bitn++;
        if (bitn == 8) got_q.push_back(sh);
      end else bitn = 0;
    end else if (!scl_l && scl_p) begin
      slv_pull <= (bitn == 8) && (got_q.size() != nack_at);
    end
  end

  // Reference model
  logic [7:0] exp_q[$];
  int exp_stops, exp_err, exp_eidx;

  task automatic model(input int nack_b);
    int nb;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  b[4];
    exp_q.delete(); exp_stops = 0; exp_err = 0; exp_eidx = 0; nb = 0;
    for (int i = 0; i < NENT; i++) begin
      a = rom[i][23:8]; d = rom[i][7:0];
      if (a == 16'hFFFF) break;
      if (a == 16'hFFFE) continue;
      b[0] = {DEV, 1'b0}; b[1] = a[15:8]; b[2] = a[7:0]; b[3] = d;
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(b[k]); nb++;
        if (nb == nack_b) begin
          exp_err = 1; exp_eidx = i; exp_stops++; return;
        end
      end
      exp_stops++;
    end
  endtask

  int errors = 0, checks = 0, last_rel = 0, done_gap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; @(negedge clk); @(negedge clk); mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    logic ps;
    n = 0; ps = sda_oe; last_rel = cyc;
    while (busy && n < budget) begin
      @(negedge clk); n++;
      if (ps && !sda_oe && !scl_oe) last_rel = cyc;
      ps = sda_oe;
    end
    done_gap = cyc - last_rel;
    check("run_finished", 32'(n < budget), 32'd1);
  endtask

  task automatic cmp_run(input string tag);
    int m;
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    check({tag, "_stops"}, stop_t.size(), exp_stops);
    check({tag, "_error"}, {31'd0, error}, 32'(exp_err));
    check({tag, "_done"}, {31'd0, done}, 32'(exp_err == 0));
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    if (exp_err != 0) check({tag, "_err_idx"}, {29'd0, err_idx}, 32'(exp_eidx));
  endtask

  task automatic full_run(input string tag, input int nb);
    model(nb); nack_at = nb;
    clr_mon(); pulse_start(); wait_idle(8000);
    cmp_run(tag);
  endtask

  task automatic set_tbl2();
    for (int i = 0; i < NENT; i++) rom[i] = 24'hFFFF00;
    rom[0] = {16'h0100, 8'h01};
  endtask

  initial begin
    int n, g, g1, g2, ns, nst;
    logic [15:0] ra;
    rst_n = 1'b0; start = 1'b0;
    set_tbl2();
    repeat (3) @(negedge clk);
    check("rst_mipi", {31'd0, mipi_rst}, 0);
    check("rst_oe", {30'd0, scl_oe, sda_oe}, 0);
    check("rst_status", {29'd0, busy, done, error}, 0);
    check("rst_idx", {26'd0, tbl_idx, err_idx}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset sequencing timing, then the single-write table
    clr_mon(); model(0); nack_at = 0; pulse_start();
    n = 0;
    while (!mipi_rst && n < 1000) begin n++; @(negedge clk); end
    check("rst_hold_cycles", n, HOLD);
    g = 0;
    while (!(sda_oe && !scl_oe) && g < 1000) begin g++; @(negedge clk); end
    $display("post-reset gap to first START: %0d cycles", g);
    check("post_rst_gap", 32'(g >= POST && g <= POST + 4 + 2 * QTR), 1);
    wait_idle(8000);
    cmp_run("single_write");
    check("bytes_literal", {got_q.size() > 3 ? got_q[0] : 8'h00, got_q.size() > 3 ? got_q[3] : 8'h00}, 16'h6C01);
    check("done_latency", 32'(done_gap >= 1 && done_gap <= QTR + 3), 1);

    // NACK on the third byte of entry 2
    for (int i = 0; i < NENT; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h301234; rom[1] = 24'h3108A5; rom[2] = 24'h400077;
    full_run("nack", 11);
    ns = got_q.size(); nst = start_t.size();
    repeat (100) @(negedge clk);
    check("nack_quiet_oe", {30'd0, scl_oe, sda_oe}, 0);
    check("nack_quiet_bus", 32'(got_q.size() == ns && start_t.size() == nst), 1);

    // Delay entries: 5 ms then zero-length
    for (int i = 0; i < NENT; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h0100AA; rom[1] = 24'hFFFE05; rom[2] = 24'h0200BB;
    rom[3] = 24'hFFFE00; rom[4] = 24'h0300CC;
    full_run("delay", 0);
    check("delay_starts", start_t.size(), 3);
    if (start_t.size() == 3 && stop_t.size() == 3) begin
      g1 = start_t[1] - stop_t[0]; g2 = start_t[2] - stop_t[1];
      $display("delay gaps: %0d %0d", g1, g2);
      check("gap_5ms", 32'(g1 >= 5 * MSC && g1 <= 5 * MSC + 2 * QTR + 8), 1);
      check("gap_0ms", 32'(g2 <= 2 * QTR + 8), 1);
    end

    // Full table with no end marker: stops at the last index
    for (int i = 0; i < NENT; i++) rom[i] = {8'h20, 8'(i), 8'(8'h10 + i)};
    full_run("full_tbl", 0);
    check("full_tbl_idx", {29'd0, tbl_idx}, 7);

    // Async reset mid-byte of entry 1, then re-run
    for (int i = 0; i < NENT; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h0100AA; rom[1] = 24'h0200BB;
    model(0); nack_at = 0; clr_mon(); pulse_start();
    n = 0;
    while (got_q.size() < 5 && n < 4000) begin n++; @(negedge clk); end
    repeat (20) @(negedge clk);
    check("pre_rst_active", {30'd0, busy, mipi_rst}, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_oe", {30'd0, scl_oe, sda_oe}, 0);
    check("async_rst_busy_mipi", {30'd0, busy, mipi_rst}, 0);
    @(negedge clk); rst_n = 1'b1;
    set_tbl2();
    full_run("after_rst", 0);

    // start during WRITE is ignored; start in DONE restarts
    model(0); nack_at = 0; clr_mon(); pulse_start();
    n = 0;
    while (got_q.size() < 2 && n < 4000) begin n++; @(negedge clk); end
    pulse_start();
    check("ign_start", {28'd0, mipi_rst, busy, tbl_idx == 3'd0, 1'b1}, 32'hF);
    wait_idle(8000);
    cmp_run("ign_run");
    pulse_start();
    check("restart_mipi", {31'd0, mipi_rst}, 0);
    check("restart_status", {29'd0, busy, done, error}, 3'b100);
    clr_mon();
    wait_idle(8000);
    cmp_run("restart_run");

    // Randomized tables
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NENT; i++) begin
        g = $urandom_range(0, 9);
        ra = 16'($urandom_range(0, 16'hFFFD));
        if (g == 0)      rom[i] = {16'hFFFE, 8'($urandom_range(0, 2))};
        else if (g == 1) rom[i] = {16'hFFFF, 8'h00};
        else             rom[i] = {ra, 8'($urandom_range(0, 255))};
      end
      full_run("rand", (r == 3) ? $urandom_range(1, 16) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
